turn_input_cond: RTL and testbench

TURN_INPUT_COND -- requirements
Module: turn_input_cond

---
 rtl/turn_input_cond.sv | 90 +++++++++
 tb/tb_turn_input_cond.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/turn_input_cond.sv
// Turn-signal input conditioner: synchronizes and debounces the left/right/hazard
// switches, resolves them into one request, and generates the pattern-advance tick.

module turn_input_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic upd
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1, s2;
  logic [7:0] cnt;

  // Update fires on the edge that completes a full run of differing samples.
  assign upd = (s2 != db) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (upd) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

module turn_input_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic l_raw,
  input  logic r_raw,
  input  logic h_raw,
  output logic L,
  output logic R,
  output logic H,
  output logic tick
);
  localparam int          NUM_LANES = 3;
  localparam logic [15:0] TC_LAST   = 16'(TICK_DIV - 1);

  logic [NUM_LANES-1:0] raw, db, upd;
  logic [15:0]          tc;
  logic                 hz;

  assign raw = {h_raw, r_raw, l_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    turn_input_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .db   (db[i]),
      .upd  (upd[i])
    );
  end

  // Both turns at once means hazard; hazard masks the individual turns.
  assign hz = db[2] | (db[0] & db[1]);
  assign H  = hz;
  assign L  = db[0] & ~hz;
  assign R  = db[1] & ~hz;

  // Any level change realigns the pattern phase so the first tick is a full period away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             tc <= '0;
    else if (|upd)          tc <= '0;
    else if (tc == TC_LAST) tc <= '0;
    else                    tc <= tc + 16'd1;
  end

  assign tick = (tc == TC_LAST);
endmodule

// File: tb/tb_turn_input_cond.sv
// Bench for turn_input_cond: directed scenarios plus random switch activity,
// all compared against a sample-window reference model.

module tb_turn_input_cond;
  localparam int D  = 4;
  localparam int TD = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic l_raw = 1'b0, r_raw = 1'b0, h_raw = 1'b0;
  logic L, R, H, tick;

  int n_chk = 0, n_err = 0;

  turn_input_cond #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clk  (clk),
    .reset(reset),
    .l_raw(l_raw),
    .r_raw(r_raw),
    .h_raw(h_raw),
    .L    (L),
    .R    (R),
    .H    (H),
    .tick (tick)
  );

  always #5 clk = ~clk;

  // Reference: a sample reaches the qualifier two edges after capture; a level
  // flips once the last D qualifier samples all disagree with it.
  logic [2:0] rawq[$];
  logic [2:0] seenq[$];
  logic [2:0] mdb;
  int         phase;

  function automatic void model_reset();
    rawq  = '{3'b000, 3'b000};
    seenq = {};
    mdb   = 3'b000;
    phase = 0;
  endfunction

  function automatic void model_step(input logic [2:0] r3);
    logic [2:0] seen;
    bit any, all;
    rawq.push_back(r3);
    seen = rawq.pop_front();
    seenq.push_back(seen);
    if (seenq.size() > D) void'(seenq.pop_front());
    any = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (seenq.size() == D) begin
        all = 1;
        for (int i = 0; i < D; i++) if (seenq[i][ch] == mdb[ch]) all = 0;
        if (all) begin
          mdb[ch] = ~mdb[ch];
          any = 1;
        end
      end
    end
    phase = any ? 0 : phase + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
  task automatic step(input logic l, input logic r, input logic h);
    logic hz;
    l_raw = l; r_raw = r; h_raw = h;
    @(posedge clk);
    model_step({h, r, l});
    @(negedge clk);
    hz = mdb[2] | (mdb[0] & mdb[1]);
    chk("H", 32'(H), 32'(hz));
    chk("L", 32'(L), 32'(mdb[0] & ~hz));
    chk("R", 32'(R), 32'(mdb[1] & ~hz));
    chk("tick", 32'(tick), 32'((phase % TD) == TD - 1));
    chk("lr_excl", 32'(L & R), 32'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_H", 32'(H), 32'd0);
    chk("rst_L", 32'(L), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("por_L", 32'(L), 32'd0);
    chk("por_R", 32'(R), 32'd0);
    chk("por_H", 32'(H), 32'd0);
    chk("por_tick", 32'(tick), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle tick cadence: first pulse after edge 7, then every 8.
    for (int k = 1; k <= 24; k++) begin
      step(0, 0, 0);
      chk("cadence", 32'(tick), 32'((k % 8) == 7));
    end

    // Clean step on left.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0);
      chk("step_L", 32'(L), 32'(k >= 6));
      chk("step_RH", 32'(R | H), 32'd0);
    end
    // Tick re-phased by the update at edge 6: pulse only after edge 13.
    for (int k = 9; k <= 22; k++) begin
      step(1, 0, 0);
      chk("realign", 32'(tick), 32'((k - 6) % 8 == 7));
    end

    // Short glitch is rejected and does not disturb the tick.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(k <= 3, 0, 0);
      chk("glitch_L", 32'(L), 32'd0);
      chk("glitch_tick", 32'(tick), 32'((k % 8) == 7));
    end

    // Both turns resolve to hazard; releasing right leaves left.
    do_reset();
    for (int k = 1; k <= 6; k++) step(1, 1, 0);
    chk("both_H", 32'(H), 32'd1);
    chk("both_LR", 32'({L, R}), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0);
      chk("rel_H", 32'(H), 32'(k < 6));
      chk("rel_L", 32'(L), 32'(k >= 6));
    end

    // Async reset while hazard is active, then requalification.
    do_reset();
    for (int k = 1; k <= 8; k++) step(0, 0, 1);
    chk("pre_H", 32'(H), 32'd1);
    h_raw = 1'b1;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 1);
      chk("rerun_H", 32'(H), 32'(k >= 6));
    end

    // Bounce on release: hazard drops 6 edges after the final stable 0.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, (i < 10) ? (((i / 2) % 2) == 1) : 1'b0);
      chk("bounce_H", 32'(H), 32'(i < 13));
    end

    // Random activity with occasional mid-cycle resets.
    do_reset();
    begin
      logic [2:0] cur = 3'b000;
      for (int n = 0; n < 3000; n++) begin
        for (int ch = 0; ch < 3; ch++)
          if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
        if ($urandom_range(0, 399) == 0) do_reset();
        step(cur[0], cur[1], cur[2]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
